// File: rtl/mouse_tile_click.sv
// Debounced mouse click decoder: converts the raw left button and cursor position
// into single-cycle click pulses tagged with the tile index under the cursor.
module mouse_tile_click #(
    parameter int GRID_COLS = 4,
    parameter int GRID_ROWS = 2,
    parameter int X_ORIGIN  = 64,
    parameter int Y_ORIGIN  = 96,
    parameter int TILE_W    = 128,
    parameter int TILE_H    = 128,
    parameter int GAP       = 32,
    parameter int DB_CYCLES = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      MouseLeft,
    input  logic [11:0]                               xpos,
    input  logic [11:0]                               ypos,
    output logic                                      click_valid,
    output logic [$clog2(GRID_COLS*GRID_ROWS)-1:0]    click_tile,
    output logic                                      btn_held,
    output logic                                      hover_valid,
    output logic [$clog2(GRID_COLS*GRID_ROWS)-1:0]    hover_tile
);

    localparam int TILE_BITS = $clog2(GRID_COLS*GRID_ROWS);
    localparam int CNT_W     = $clog2(DB_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        MISS_HELD,
        RELEASE_DB
    } state_t;

    state_t               state, state_nxt;
    logic                 ml_q1, ml_s;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 hit_valid;
    logic [TILE_BITS-1:0] hit_tile;
    logic [TILE_BITS-1:0] press_tile;
    logic                 latch_press;
    logic                 fire, fire_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, exactly like the hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ml_q1 <= 1'b0;
            ml_s  <= 1'b0;
        end else begin
            ml_q1 <= MouseLeft;
            ml_s  <= ml_q1;
        end
    end

    assign accept = (ml_s != btn_held) && (cnt == CNT_W'(DB_CYCLES - 1));

    // Counter only runs while the synchronized level disagrees with btn_held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            btn_held <= 1'b0;
        end else if (ml_s == btn_held) begin
            cnt <= '0;
        end else if (accept) begin
            cnt      <= '0;
            btn_held <= ~btn_held;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        int col_idx;
        int row_idx;
        logic col_hit;
        logic row_hit;
        col_idx = 0;
        row_idx = 0;
        col_hit = 1'b0;
        row_hit = 1'b0;
        for (int c = 0; c < GRID_COLS; c++) begin
            if (int'(xpos) >= X_ORIGIN + c*(TILE_W + GAP) &&
                int'(xpos) <  X_ORIGIN + c*(TILE_W + GAP) + TILE_W) begin
                col_hit = 1'b1;
                col_idx = c;
            end
        end
        for (int r = 0; r < GRID_ROWS; r++) begin
            if (int'(ypos) >= Y_ORIGIN + r*(TILE_H + GAP) &&
                int'(ypos) <  Y_ORIGIN + r*(TILE_H + GAP) + TILE_H) begin
                row_hit = 1'b1;
                row_idx = r;
            end
        end
        hit_valid = col_hit && row_hit;
        hit_tile  = hit_valid ? TILE_BITS'(row_idx*GRID_COLS + col_idx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hover_valid <= 1'b0;
            hover_tile  <= '0;
        end else begin
            hover_valid <= hit_valid;
            hover_tile  <= hit_tile;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:       if (ml_s) state_nxt = PRESS_DB;
            PRESS_DB: begin
                if (!ml_s)       state_nxt = IDLE;
                else if (accept) state_nxt = hover_valid ? HELD : MISS_HELD;
            end
            HELD:       if (!ml_s) state_nxt = RELEASE_DB;
            RELEASE_DB: begin
                if (ml_s)        state_nxt = HELD;
                else if (accept) state_nxt = IDLE;
            end
            MISS_HELD:  if (accept) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        latch_press = (state == PRESS_DB) && accept && hover_valid;
        fire        = (state == RELEASE_DB) && accept && !ml_s &&
                      hover_valid && (hover_tile == press_tile);
    end

    // The release decision lands with btn_held; the pulse follows one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_tile  <= '0;
            fire_q      <= 1'b0;
            click_valid <= 1'b0;
            click_tile  <= '0;
        end else begin
            if (latch_press) press_tile <= hover_tile;
            fire_q      <= fire;
            click_valid <= fire_q;
            click_tile  <= fire_q ? press_tile : '0;
        end
    end

endmodule

// File: tb/tb_mouse_tile_click.sv
// Directed bench for mouse_tile_click: hit decode, debounce, click latency and
// drag / glitch / reset handling with hand-computed expectations.
module tb_mouse_tile_click;

    logic        clk = 1'b0;
    logic        rst;
    logic        MouseLeft;
    logic [11:0] xpos, ypos;
    logic        click_valid;
    logic [2:0]  click_tile;
    logic        btn_held;
    logic        hover_valid;
    logic [2:0]  hover_tile;

    int n_assert = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int last_tile = -1;

    mouse_tile_click dut (
        .clk         (clk),
        .rst         (rst),
        .MouseLeft   (MouseLeft),
        .xpos        (xpos),
        .ypos        (ypos),
        .click_valid (click_valid),
        .click_tile  (click_tile),
        .btn_held    (btn_held),
        .hover_valid (hover_valid),
        .hover_tile  (hover_tile)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor; click_tile must read 0 whenever no pulse is present.
    always @(negedge clk) begin
        if (!rst) begin
            if (click_valid) begin
                pulse_cnt++;
                last_tile = int'(click_tile);
            end else begin
                check("click_tile_idle", 32'(click_tile), 32'd0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setpos(input int x, input int y);
        xpos = 12'(x);
        ypos = 12'(y);
    endtask

    task automatic click(input int hi, input int lo);
        MouseLeft = 1'b1;
        cyc(hi);
        MouseLeft = 1'b0;
        cyc(lo);
    endtask

    typedef struct {
        int x;
        int y;
        logic v;
        int t;
    } hov_vec_t;

    hov_vec_t hov_tab[9] = '{
        '{250, 300, 1'b1, 5},
        '{192, 300, 1'b0, 0},
        '{191, 300, 1'b1, 4},
        '{64,  96,  1'b1, 0},
        '{63,  96,  1'b0, 0},
        '{671, 383, 1'b1, 7},
        '{672, 383, 1'b0, 0},
        '{671, 384, 1'b0, 0},
        '{100, 224, 1'b0, 0}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        rst = 1'b1;
        MouseLeft = 1'b0;
        setpos(0, 0);
        cyc(3);
        check("reset_outputs", 32'({click_valid, click_tile, btn_held, hover_valid, hover_tile}), 32'd0);
        rst = 1'b0;

        // Tile 0, long hold then release; pulse exactly 19 cycles after the fall.
        setpos(100, 120);
        cyc(1);
        check("hover_t0_valid", 32'(hover_valid), 32'd1);
        check("hover_t0_tile", 32'(hover_tile), 32'd0);
        p0 = pulse_cnt;
        MouseLeft = 1'b1;
        cyc(300);
        check("hold_btn_held", 32'(btn_held), 32'd1);
        check("hold_no_pulse", 32'(pulse_cnt), 32'(p0));
        MouseLeft = 1'b0;
        cyc(17);
        check("rel_btn_still_held", 32'(btn_held), 32'd1);
        cyc(1);
        check("rel_btn_dropped", 32'(btn_held), 32'd0);
        check("lat18_no_pulse", 32'(click_valid), 32'd0);
        cyc(1);
        check("lat19_pulse", 32'(click_valid), 32'd1);
        check("lat19_tile", 32'(click_tile), 32'd0);
        cyc(1);
        check("lat20_pulse_gone", 32'(click_valid), 32'd0);
        cyc(20);
        check("t0_one_pulse", 32'(pulse_cnt), 32'(p0 + 1));

        // Hit decode table, including tile edges and gaps.
        foreach (hov_tab[i]) begin
            setpos(hov_tab[i].x, hov_tab[i].y);
            cyc(1);
            check($sformatf("hover_valid_%0d", i), 32'(hover_valid), 32'(hov_tab[i].v));
            check($sformatf("hover_tile_%0d", i), 32'(hover_tile), 32'(hov_tab[i].t));
        end

        // Click on tile 5.
        setpos(250, 300);
        p0 = pulse_cnt;
        click(40, 40);
        check("t5_count", 32'(pulse_cnt), 32'(p0 + 1));
        check("t5_tile", 32'(last_tile), 32'd5);

        // Drag from tile 0 to tile 1 before release: no pulse.
        setpos(100, 120);
        p0 = pulse_cnt;
        MouseLeft = 1'b1;
        cyc(40);
        setpos(250, 120);
        cyc(10);
        MouseLeft = 1'b0;
        cyc(40);
        check("drag_a_b_none", 32'(pulse_cnt), 32'(p0));

        // Wander off and back before release: pulse for tile 0.
        setpos(100, 120);
        cyc(2);
        MouseLeft = 1'b1;
        cyc(40);
        setpos(250, 120);
        cyc(10);
        setpos(100, 120);
        cyc(10);
        MouseLeft = 1'b0;
        cyc(40);
        check("drag_back_count", 32'(pulse_cnt), 32'(p0 + 1));
        check("drag_back_tile", 32'(last_tile), 32'd0);

        // 10-cycle glitches on tile 2 never get through the debouncer.
        setpos(400, 120);
        p0 = pulse_cnt;
        for (int i = 0; i < 6; i++) begin
            MouseLeft = 1'b1;
            cyc(10);
            check($sformatf("glitch_held_%0d", i), 32'(btn_held), 32'd0);
            MouseLeft = 1'b0;
            cyc(10);
        end
        cyc(30);
        check("glitch_no_pulse", 32'(pulse_cnt), 32'(p0));
        check("glitch_btn_low", 32'(btn_held), 32'd0);

        // Press in a gap, drag onto tile 1: no pulse; then a clean click on tile 1.
        setpos(200, 120);
        p0 = pulse_cnt;
        MouseLeft = 1'b1;
        cyc(40);
        check("gap_btn_held", 32'(btn_held), 32'd1);
        setpos(250, 120);
        cyc(5);
        MouseLeft = 1'b0;
        cyc(40);
        check("gap_drag_none", 32'(pulse_cnt), 32'(p0));
        click(40, 40);
        check("t1_count", 32'(pulse_cnt), 32'(p0 + 1));
        check("t1_tile", 32'(last_tile), 32'd1);

        // Back-to-back minimal-length clicks each pulse once.
        setpos(400, 300);
        p0 = pulse_cnt;
        click(20, 20);
        click(20, 20);
        cyc(5);
        check("b2b_count", 32'(pulse_cnt), 32'(p0 + 2));
        check("b2b_tile", 32'(last_tile), 32'd6);

        // Reset while held; release soon after reset: no pulse, then a normal click.
        setpos(100, 120);
        p0 = pulse_cnt;
        MouseLeft = 1'b1;
        cyc(40);
        check("pre_rst_held", 32'(btn_held), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", 32'({click_valid, click_tile, btn_held, hover_valid, hover_tile}), 32'd0);
        @(negedge clk);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        MouseLeft = 1'b0;
        cyc(40);
        check("post_rst_no_pulse", 32'(pulse_cnt), 32'(p0));
        check("post_rst_btn_low", 32'(btn_held), 32'd0);
        click(40, 40);
        check("post_rst_click", 32'(pulse_cnt), 32'(p0 + 1));
        check("post_rst_tile", 32'(last_tile), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mouse_tile_click.md
Name: mouse_tile_click

Overview:
- Front end of the card-flip path. Turns the raw MouseLeft button and cursor position into clean, debounced click events.
- Each event is a single-cycle pulse carrying the index of the tile that was clicked, within a GRID_COLS x GRID_ROWS grid of equal tiles.
- Downstream picture/cover logic and game control act on click_valid/click_tile, never on the raw button.
- A click counts only if both the debounced press and the debounced release land on the same tile.

Parameters:
- GRID_COLS, 4, tiles per row
- GRID_ROWS, 2, tile rows
- X_ORIGIN, 64, x of left edge of tile column 0
- Y_ORIGIN, 96, y of top edge of tile row 0
- TILE_W, 128, tile width in pixels
- TILE_H, 128, tile height in pixels
- GAP, 32, pixels between adjacent tiles, both axes
- DB_CYCLES, 16, consecutive stable cycles required to accept a button edge (>=2)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- MouseLeft  in  1  raw left button, asynchronous to clk
- xpos  in  12  cursor x, clk domain
- ypos  in  12  cursor y, clk domain
- click_valid  out  1  one-cycle pulse: completed click on a tile
- click_tile  out  $clog2(GRID_COLS*GRID_ROWS)  tile index (row*GRID_COLS+col); valid only with click_valid
- btn_held  out  1  debounced button level
- hover_valid  out  1  registered: cursor is inside some tile
- hover_tile  out  same as click_tile  registered tile under cursor; 0 when hover_valid=0

Behaviour:
- Reset is async, active-high, released synchronously by the system.
- Reset values: all outputs 0, synchronizer flops 0, counter 0, state IDLE.
- Button path: MouseLeft passes through 2 flops to give ml_s. Debounce counter cnt resets to 0 whenever ml_s equals the current debounced level.
- Edge acceptance: when ml_s differs from the debounced level for DB_CYCLES consecutive cycles, the edge is accepted and btn_held toggles on the next edge.
- Any glitch shorter than DB_CYCLES restarts the count.
- Hit decode, column c:
  - c is in range when x >= X_ORIGIN + c*(TILE_W+GAP) and x < that value + TILE_W (half-open interval).
  - Rows use the same rule with Y_ORIGIN/TILE_H.
  - A point in a gap, left/above the origin, or beyond the last tile is a miss.
- hover_valid/hover_tile are registered from the current xpos/ypos: 1-cycle latency.
- Press/release decisions use the hover_* values registered in the cycle the edge is accepted.
- FSM states: IDLE, PRESS_DB, HELD, MISS_HELD, RELEASE_DB.
  - IDLE: ml_s=1 -> PRESS_DB.
  - PRESS_DB: ml_s falls before DB_CYCLES -> IDLE. Press accepted with hover_valid=1 -> latch press_tile, go HELD. Press accepted with hover_valid=0 -> MISS_HELD.
  - HELD: ml_s=0 -> RELEASE_DB.
  - RELEASE_DB: ml_s returns to 1 before DB_CYCLES -> HELD. Release accepted -> IDLE. If hover_valid=1 and hover_tile==press_tile, drive click_valid=1 and click_tile=press_tile in the next cycle, for exactly one cycle.
  - MISS_HELD: release accepted -> IDLE; no pulse.
- Total latency from a stable MouseLeft fall to click_valid is 2 + DB_CYCLES + 1 cycles.
- Drag handling: a drag from tile A to tile B, or from a tile into a gap, produces no pulse. A drag from a gap onto a tile produces no pulse either.
- Cursor moving while held does not affect press_tile.
- Held position: holding indefinitely produces no pulse. The counter saturates, no wrap.
- Repeat clicks: back-to-back clicks on the same tile each produce one pulse. The minimum spacing between pulses is 2*DB_CYCLES.
- click_tile is 0 whenever click_valid=0.
- Reset mid-operation, in any state: returns to IDLE with no pulse. A button still held after reset is treated as a new press only after debounce.

Test Plan:
- Defaults; xpos=100, ypos=120; clean press 40 cycles, release -> exactly one click_valid, click_tile=0, 19 cycles after MouseLeft falls.
- xpos=250, ypos=300 (col 1, row 1) -> hover_tile=5 one cycle later. Click -> click_tile=5. xpos=192 (gap) -> hover_valid=0.
- Press at x=100,y=120; move to x=250 before release -> no click_valid. Move back to x=100 before release -> click_tile=0.
- MouseLeft pulses of 10 cycles high/10 low, repeated, cursor on tile 2 (x=400) -> btn_held stays 0, no click_valid.
- Press in gap (x=200), drag onto tile 1, release -> no pulse. Then a normal click on tile 1 -> pulse with click_tile=1.
- Assert rst during HELD with the button held -> outputs 0 immediately. Release after rst deasserts -> no pulse. Next full click -> one pulse.
